// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the multiplexed RTC bus master: FSM states,
// phase-select encoding of ad_n, and the RTC register map.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_RECOV,
        ST_RESP
    } rtc_state_e;

    // Value of ad_n: low marks the address phase of a bus cycle.
    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_sel_e;

    localparam logic [7:0] RTC_REG_SEC        = 8'h20;
    localparam logic [7:0] RTC_REG_MIN        = 8'h21;
    localparam logic [7:0] RTC_REG_HOUR       = 8'h22;
    localparam logic [7:0] RTC_REG_DATE       = 8'h23;
    localparam logic [7:0] RTC_REG_MONTH      = 8'h24;
    localparam logic [7:0] RTC_REG_YEAR       = 8'h25;
    localparam logic [7:0] RTC_REG_TIMER_CTRL = 8'h40;
    localparam logic [7:0] RTC_REG_TIMER_CNT  = 8'h41;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_mux_bus_master_if.sv
// Command/response channels and pad signals of the RTC bus master.
// With RTC_BCD_CHECK_EN defined the response carries a BCD error flag.
interface rtc_mux_bus_master_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [LEN_W-1:0]  cmd_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
`ifdef RTC_BCD_CHECK_EN
    logic              rsp_bcd_err;
`endif
    logic              busy;
    logic              cs_n;
    logic              ad_n;
    logic              rd_n;
    logic              wr_n;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;

    modport master (
`ifdef RTC_BCD_CHECK_EN
        output rsp_bcd_err,
`endif
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready, ad_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_last, busy,
        output cs_n, ad_n, rd_n, wr_n, ad_out, ad_oe
    );

    modport slave (
`ifdef RTC_BCD_CHECK_EN
        input  rsp_bcd_err,
`endif
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready, ad_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last, busy,
        input  cs_n, ad_n, rd_n, wr_n, ad_out, ad_oe
    );

endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; last is high on the final cycle.
// Load with (phase length - 1) on the edge that enters the phase.
module rtc_phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/rtc_mux_bus_master.sv
// Multiplexed address/data RTC bus master with programmable phase timing and
// auto-incrementing burst reads. Optional RTC_BCD_CHECK_EN adds rsp_bcd_err.
//
// state | meaning
// IDLE  | cmd_ready high, bus inactive
// ADDR  | cs_n/ad_n low, address driven
// GAP   | bus released between address and strobe
// DATA  | rd_n or wr_n low; read data captured on last cycle
// RECOV | bus inactive recovery after each beat
// RESP  | read data presented until rsp_ready
module rtc_mux_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int T_ADDR  = 4,
    parameter int T_GAP   = 2,
    parameter int T_DATA  = 6,
    parameter int T_RECOV = 8,
    parameter int MAX_LEN = 8
) (
    input logic                  clk,
    input logic                  reset,
    rtc_mux_bus_master_if.master bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int T_MAX = max_int(max_int(T_ADDR, T_GAP), max_int(T_DATA, T_RECOV));
    localparam int CW    = $clog2(T_MAX + 1);

    rtc_state_e        state;
    logic              wr_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LEN_W-1:0]  remain_q;
    logic [LEN_W-1:0]  len_eff;
    logic              accept;
    logic              rsp_hs;
    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              tmr_last;

    assign accept = (state == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;
    assign rsp_hs = (state == ST_RESP) && bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        if (bus.cmd_len == '0)
            len_eff = LEN_W'(1);
        else if (bus.cmd_len > LEN_W'(MAX_LEN))
            len_eff = LEN_W'(MAX_LEN);
        else
            len_eff = bus.cmd_len;
    end

    // The timer is reloaded on the same edge that enters the next phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = CW'(T_ADDR - 1);
        case (state)
            ST_IDLE: tmr_load = accept;
            ST_ADDR: begin tmr_load = tmr_last; tmr_val = CW'(T_GAP - 1);   end
            ST_GAP:  begin tmr_load = tmr_last; tmr_val = CW'(T_DATA - 1);  end
            ST_DATA: begin tmr_load = tmr_last; tmr_val = CW'(T_RECOV - 1); end
            ST_RESP: tmr_load = rsp_hs;
            default: ;
        endcase
    end

    rtc_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

`ifdef RTC_BCD_CHECK_EN
    logic bcd_bad;
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DATA_W / 4; i++)
            if (bus.rsp_data[i*4 +: 4] > 4'd9) bcd_bad = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            remain_q      <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_last  <= 1'b0;
            bus.rsp_data  <= '0;
            bus.busy      <= 1'b0;
            bus.cs_n      <= 1'b1;
            bus.ad_n      <= 1'b1;
            bus.rd_n      <= 1'b1;
            bus.wr_n      <= 1'b1;
            bus.ad_out    <= '0;
            bus.ad_oe     <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
            bus.rsp_bcd_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (accept) begin
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        wr_q          <= bus.cmd_write;
                        addr_q        <= bus.cmd_addr;
                        wdata_q       <= bus.cmd_wdata;
                        remain_q      <= bus.cmd_write ? LEN_W'(1) : len_eff;
                        state         <= ST_ADDR;
                        bus.cs_n      <= 1'b0;
                        bus.ad_n      <= PH_ADDR;
                        bus.ad_oe     <= 1'b1;
                        bus.ad_out    <= bus.cmd_addr;
                    end
                end
                ST_ADDR: if (tmr_last) begin
                    state     <= ST_GAP;
                    bus.cs_n  <= 1'b1;
                    bus.ad_n  <= PH_DATA;
                    bus.ad_oe <= 1'b0;
                end
                ST_GAP: if (tmr_last) begin
                    state    <= ST_DATA;
                    bus.cs_n <= 1'b0;
                    if (wr_q) begin
                        bus.wr_n   <= 1'b0;
                        bus.ad_oe  <= 1'b1;
                        bus.ad_out <= wdata_q;
                    end else begin
                        bus.rd_n <= 1'b0;
                    end
                end
                ST_DATA: if (tmr_last) begin
                    if (!wr_q) bus.rsp_data <= bus.ad_in;
                    state     <= ST_RECOV;
                    bus.cs_n  <= 1'b1;
                    bus.rd_n  <= 1'b1;
                    bus.wr_n  <= 1'b1;
                    bus.ad_oe <= 1'b0;
                end
                ST_RECOV: if (tmr_last) begin
                    if (wr_q) begin
                        state         <= ST_IDLE;
                        bus.busy      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end else begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_last  <= (remain_q == LEN_W'(1));
`ifdef RTC_BCD_CHECK_EN
                        bus.rsp_bcd_err <= bcd_bad;
`endif
                    end
                end
                ST_RESP: if (rsp_hs) begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_last  <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
                    bus.rsp_bcd_err <= 1'b0;
`endif
                    if (remain_q > LEN_W'(1)) begin
                        remain_q   <= remain_q - LEN_W'(1);
                        addr_q     <= addr_q + DATA_W'(1);
                        state      <= ST_ADDR;
                        bus.cs_n   <= 1'b0;
                        bus.ad_n   <= PH_ADDR;
                        bus.ad_oe  <= 1'b1;
                        bus.ad_out <= addr_q + DATA_W'(1);
                    end else begin
                        state         <= ST_IDLE;
                        bus.busy      <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// Scoreboard bench for rtc_mux_bus_master: a small RTC pad model serves read
// data, queues hold expected bus addresses and responses, monitors pop them.
module tb_rtc_mux_bus_master;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       bcd;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_mux_bus_master_if bus ();

    rtc_mux_bus_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int stall = 0;

    rsp_t       exp_q[$];
    logic [7:0] exp_addr[$];
    logic [7:0] mem[256];
    logic [7:0] lat = 8'h00;

    // RTC pad model: latch the address phase, return mem[] on ad_in.
    always @(posedge clk)
        if (!bus.cs_n && !bus.ad_n) lat <= bus.ad_out;
    assign bus.ad_in = mem[lat];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer: rsp_ready idles high, held low for 'stall' cycles per beat.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.rsp_valid) begin
                if (wcnt < stall) begin
                    bus.rsp_ready = 1'b0;
                    wcnt++;
                end else begin
                    bus.rsp_ready = 1'b1;
                end
            end else begin
                bus.rsp_ready = 1'b1;
                wcnt = 0;
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t       e;
        logic       prev_wait;
        logic [7:0] prev_data;
        logic       prev_last;
        prev_wait = 1'b0;
        prev_data = 8'h00;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !bus.rsp_valid) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait)
                    chk("rsp_hold", {bus.rsp_last, bus.rsp_data}, {prev_last, prev_data});
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: got data=%0h want no response", bus.rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data_last", {bus.rsp_last, bus.rsp_data}, {e.last, e.data});
`ifdef RTC_BCD_CHECK_EN
                        chk("rsp_bcd_err", bus.rsp_bcd_err, e.bcd);
`endif
                    end
                    prev_wait = 1'b0;
                end else begin
                    prev_wait = 1'b1;
                    prev_data = bus.rsp_data;
                    prev_last = bus.rsp_last;
                end
            end
        end
    end

    // Bus monitor: address of each address phase, and no drive during read strobe.
    initial begin
        logic prev_ap;
        prev_ap = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!bus.rd_n) chk("oe_during_rd", bus.ad_oe, 1'b0);
                if (!bus.cs_n && !bus.ad_n && !prev_ap) begin
                    if (exp_addr.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_addr: got=%0h want none", bus.ad_out);
                    end else begin
                        chk("bus_addr", bus.ad_out, exp_addr.pop_front());
                    end
                end
            end
            prev_ap = !reset && !bus.cs_n && !bus.ad_n;
        end
    end

    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                         input logic [3:0] len);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_ready_timeout: got=0 want=1");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_len   = len;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.cmd_ready && exp_q.size() == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy want idle");
        end
    endtask

    task automatic push_rsp(input logic [7:0] d, input logic l, input logic b);
        rsp_t e;
        e.data = d;
        e.last = l;
        e.bcd  = b;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [5:0] exp_ctl;
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.cmd_len   = 4'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_vals",
            {bus.cmd_ready, bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.busy,
             bus.cs_n, bus.ad_n, bus.rd_n, bus.wr_n, bus.ad_out, bus.ad_oe},
            {3'b000, 8'h00, 1'b0, 4'hF, 8'h00, 1'b0});
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.cmd_ready, 1'b1);

        // Single write: {busy,cs_n,ad_n,rd_n,wr_n,ad_oe} per cycle from ADDR entry
        exp_addr.push_back(8'h21);
        issue(1'b1, 8'h21, 8'h59, 4'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 4)       exp_ctl = 6'b100111;
            else if (c < 6)  exp_ctl = 6'b111110;
            else if (c < 12) exp_ctl = 6'b101101;
            else             exp_ctl = 6'b111110;
            chk("wr_ctl", {bus.busy, bus.cs_n, bus.ad_n, bus.rd_n, bus.wr_n, bus.ad_oe}, exp_ctl);
            if (c < 4)                chk("wr_ad_addr", bus.ad_out, 8'h21);
            else if (c >= 6 && c < 12) chk("wr_ad_data", bus.ad_out, 8'h59);
        end
        @(negedge clk);
        chk("wr_done", {bus.cmd_ready, bus.busy}, 2'b10);

        // Single read: rsp_valid in cycle 21 counting the first ADDR cycle as 1
        mem[8'h41] = 8'h23;
        stall = 0;
        exp_addr.push_back(8'h41);
        push_rsp(8'h23, 1'b1, 1'b0);
        issue(1'b0, 8'h41, 8'h00, 4'd1);
        k = 0;
        @(negedge clk);
        while (!bus.rsp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rd_latency", k, 20);
        wait_idle();

        // Burst read with backpressure
        mem[8'h24] = 8'h11;
        mem[8'h25] = 8'h22;
        mem[8'h26] = 8'h33;
        stall = 5;
        exp_addr.push_back(8'h24);
        exp_addr.push_back(8'h25);
        exp_addr.push_back(8'h26);
        push_rsp(8'h11, 1'b0, 1'b0);
        push_rsp(8'h22, 1'b0, 1'b0);
        push_rsp(8'h33, 1'b1, 1'b0);
        issue(1'b0, 8'h24, 8'h00, 4'd3);
        wait_idle();
        stall = 0;

        // Address wrap
        mem[8'hFF] = 8'h45;
        mem[8'h00] = 8'h67;
        exp_addr.push_back(8'hFF);
        exp_addr.push_back(8'h00);
        push_rsp(8'h45, 1'b0, 1'b0);
        push_rsp(8'h67, 1'b1, 1'b0);
        issue(1'b0, 8'hFF, 8'h00, 4'd2);
        wait_idle();

        // len=0 gives one beat
        mem[8'h10] = 8'h09;
        exp_addr.push_back(8'h10);
        push_rsp(8'h09, 1'b1, 1'b0);
        issue(1'b0, 8'h10, 8'h00, 4'd0);
        wait_idle();

        // len=15 clamps to 8 beats
        for (int i = 0; i < 8; i++) begin
            mem[8'h30 + i] = 8'h50 + 8'(i);
            exp_addr.push_back(8'h30 + 8'(i));
            push_rsp(8'h50 + 8'(i), (i == 7), 1'b0);
        end
        stall = 1;
        issue(1'b0, 8'h30, 8'h00, 4'd15);
        wait_idle();
        stall = 0;

        // Reset in the middle of a read strobe
        exp_addr.push_back(8'h41);
        issue(1'b0, 8'h41, 8'h00, 4'd1);
        repeat (8) @(negedge clk);
        chk("pre_reset_rd", {bus.rd_n, bus.cs_n}, 2'b00);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_data",
            {bus.cs_n, bus.ad_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.rsp_valid, bus.busy, bus.cmd_ready},
            8'b1111_0000);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", bus.cmd_ready, 1'b1);
        repeat (30) @(negedge clk);

`ifdef RTC_BCD_CHECK_EN
        mem[8'h50] = 8'h5A;
        mem[8'h51] = 8'h59;
        exp_addr.push_back(8'h50);
        exp_addr.push_back(8'h51);
        push_rsp(8'h5A, 1'b0, 1'b1);
        push_rsp(8'h59, 1'b1, 1'b0);
        issue(1'b0, 8'h50, 8'h00, 4'd2);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        chk("rsp_queue_drained", exp_q.size(), 0);
        chk("addr_queue_drained", exp_addr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
